// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs: AXI4-Lite slave register bank with independent write and read FSMs.
module axi4_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDXW  = $clog2(NUM_REGS);

    typedef enum logic {WR_COLLECT, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[LSB-1:0] == '0) && ((a >> (LSB + IDXW)) == '0);
    endfunction

    function automatic logic [IDXW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[LSB +: IDXW];
    endfunction

    wr_state_e             wr_state_q, wr_state_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wval;

    rd_state_e             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        we         = 1'b0;
        // A payload being accepted this edge takes priority over nothing held yet
        waddr      = aw_held_q ? awaddr_q : AWADDR;
        wval       = w_held_q ? wdata_q : WDATA;
        if (wr_state_q == WR_COLLECT) begin
            aw_held_d = aw_held_q | (AWVALID & awready_q);
            w_held_d  = w_held_q | (WVALID & wready_q);
            awaddr_d  = (AWVALID & awready_q) ? AWADDR : awaddr_q;
            wdata_d   = (WVALID & wready_q) ? WDATA : wdata_q;
            if (aw_held_d && w_held_d) begin
                we         = addr_ok(waddr);
                bresp_d    = we ? 2'b00 : 2'b10;
                bvalid_d   = 1'b1;
                awready_d  = 1'b0;
                wready_d   = 1'b0;
                wr_state_d = WR_RESP;
            end else begin
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;
            end
        end else if (BREADY) begin
            bvalid_d   = 1'b0;
            aw_held_d  = 1'b0;
            w_held_d   = 1'b0;
            awready_d  = 1'b1;
            wready_d   = 1'b1;
            wr_state_d = WR_COLLECT;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        if (rd_state_q == RD_IDLE) begin
            arready_d = 1'b1;
            if (ARVALID && arready_q) begin
                arready_d  = 1'b0;
                rvalid_d   = 1'b1;
                rdata_d    = addr_ok(ARADDR) ? regs_q[addr_idx(ARADDR)*DATA_WIDTH +: DATA_WIDTH] : '0;
                rresp_d    = addr_ok(ARADDR) ? 2'b00 : 2'b10;
                rd_state_d = RD_RESP;
            end
        end else if (RREADY) begin
            rvalid_d   = 1'b0;
            rdata_d    = '0;
            arready_d  = 1'b1;
            rd_state_d = RD_IDLE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_state_q <= WR_COLLECT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            regs_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            if (we) regs_q[addr_idx(waddr)*DATA_WIDTH +: DATA_WIDTH] <= wval;
        end
    end
endmodule
